// File: rtl/ctrl_spi_rx.sv
// Mode-0 SPI control-frame receiver feeding the drawbar registers a16/a8/a5/a4; CTRL_PARITY_EN adds a trailing even-parity bit.
// Latency: register write and upd_valid appear SYNC_STAGES+2 clk_50 cycles after SS_n high is first sampled.
// Backpressure: none; the master is never stalled, and rejected frames only pulse frame_err.
module ctrl_spi_rx #(
    parameter int                A_BITS      = 3,
    parameter logic [A_BITS-1:0] RST_VAL     = A_BITS'(4),
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk_50,
    input  logic              reset_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic [A_BITS-1:0] a16,
    output logic [A_BITS-1:0] a8,
    output logic [A_BITS-1:0] a5,
    output logic [A_BITS-1:0] a4,
    output logic              upd_valid,
    output logic [1:0]        upd_addr,
    output logic              frame_err
);

`ifdef CTRL_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int               FRAME_LEN = 16 + PAR_BITS;
    localparam int               CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_hist;
    logic                   mosi_hist;
    logic                   ss_hist;
    logic                   sclk_rise;
    logic                   ss_rise;
    logic                   ss_fall;
    logic [SYNC_STAGES:0]   settle;
    logic                   armed;

    state_t                 state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [FRAME_LEN-1:0]   shreg;
    logic [3:0]             frame_addr;
    logic [A_BITS-1:0]      frame_data;
    logic                   parity_ok;
    logic                   frame_ok;

    // Edge pulses are registered; mosi_hist is the MOSI sample aligned with sclk_rise.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_hist <= 1'b0;
            mosi_hist <= 1'b0;
            ss_hist   <= 1'b1;
            sclk_rise <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
            settle    <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            sclk_hist <= sclk_sync[SYNC_STAGES-1];
            mosi_hist <= mosi_sync[SYNC_STAGES-1];
            ss_hist   <= ss_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
            ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_hist;
            ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_hist;
            settle    <= {settle[SYNC_STAGES-1:0], 1'b1};
            // The chain's reset value of 1 would fake a falling edge if SS_n is
            // already low; only accept a fall once a real high has been seen.
            if (settle[SYNC_STAGES] && ss_hist)
                armed <= 1'b1;
        end
    end

    assign frame_addr = shreg[FRAME_LEN-1 -: 4];
    assign frame_data = shreg[PAR_BITS +: A_BITS];

`ifdef CTRL_PARITY_EN
    assign parity_ok = ~^shreg;
`else
    logic unused_shreg;
    assign parity_ok    = 1'b1;
    assign unused_shreg = ^shreg;
`endif

    assign frame_ok = (bit_cnt == FRAME_CNT) && (frame_addr[3:2] == 2'b00) && parity_ok;

    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            a16       <= RST_VAL;
            a8        <= RST_VAL;
            a5        <= RST_VAL;
            a4        <= RST_VAL;
            upd_valid <= 1'b0;
            upd_addr  <= 2'd0;
            frame_err <= 1'b0;
        end else begin
            upd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall && armed) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                SHIFT: begin
                    // SS_n rise has priority over a coincident SCLK rise.
                    if (ss_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        if (bit_cnt == FRAME_CNT) begin
                            state <= OVERRUN;
                        end else begin
                            shreg   <= {shreg[FRAME_LEN-2:0], mosi_hist};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                OVERRUN: begin
                    if (ss_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (frame_ok) begin
                        upd_valid <= 1'b1;
                        upd_addr  <= frame_addr[1:0];
                        case (frame_addr[1:0])
                            2'd0: a16 <= frame_data;
                            2'd1: a8  <= frame_data;
                            2'd2: a5  <= frame_data;
                            2'd3: a4  <= frame_data;
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_spi_rx.sv
// Bench for ctrl_spi_rx: directed edge cases plus random frames scored against a frame-level model.
`timescale 1ns/1ps
module tb_ctrl_spi_rx;
    localparam int                A_BITS      = 3;
    localparam int                SYNC_STAGES = 2;
    localparam logic [A_BITS-1:0] RST_VAL     = 3'd4;
`ifdef CTRL_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int FLEN = 16 + PAR;
    localparam int LAT  = SYNC_STAGES + 2;

    logic              clk_50   = 1'b0;
    logic              reset_n  = 1'b0;
    logic              spi_sclk = 1'b0;
    logic              spi_mosi = 1'b0;
    logic              spi_ss_n = 1'b1;
    logic [A_BITS-1:0] a16, a8, a5, a4;
    logic              upd_valid;
    logic [1:0]        upd_addr;
    logic              frame_err;

    always #10 clk_50 = ~clk_50;

    ctrl_spi_rx #(.A_BITS(A_BITS), .RST_VAL(RST_VAL), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_50    (clk_50),
        .reset_n   (reset_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_ss_n  (spi_ss_n),
        .a16       (a16),
        .a8        (a8),
        .a5        (a5),
        .a4        (a4),
        .upd_valid (upd_valid),
        .upd_addr  (upd_addr),
        .frame_err (frame_err)
    );

    int                n_checks = 0;
    int                n_fail   = 0;
    int                n_upd    = 0;
    int                n_err    = 0;
    int                n_both   = 0;
    logic [1:0]        last_addr;
    logic [A_BITS-1:0] exp_reg [4];

    always @(negedge clk_50) begin
        if (upd_valid) begin
            n_upd++;
            last_addr = upd_addr;
        end
        if (frame_err) n_err++;
        if (upd_valid && frame_err) n_both++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [A_BITS-1:0] reg_of(input int i);
        case (i)
            0:       return a16;
            1:       return a8;
            2:       return a5;
            default: return a4;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("%s reg%0d", tag, i), reg_of(i), exp_reg[i]);
    endtask

    // Frame as it goes on the wire: {addr, 12-bit data} then the even-parity bit if enabled.
    function automatic logic [31:0] make_frame(input int addr, input int data, input bit bad_par);
        logic [15:0] payload;
        payload = {addr[3:0], data[11:0]};
`ifdef CTRL_PARITY_EN
        return {15'b0, payload, (^payload) ^ bad_par};
`else
        return {16'b0, payload};
`endif
    endfunction

    // Reference: a frame is accepted only at exactly FLEN bits, address below 4 and good parity.
    task automatic model_frame(input logic [31:0] word, input int nbits, output bit wr, output int addr);
        logic [31:0] payload;
        bit          par_ok;
        payload = word >> PAR;
        addr    = int'(payload[15:12]);
`ifdef CTRL_PARITY_EN
        par_ok  = ((^word[FLEN-1:0]) == 1'b0);
`else
        par_ok  = 1'b1;
`endif
        wr = (nbits == FLEN) && (addr < 4) && par_ok;
        if (wr) exp_reg[addr] = payload[A_BITS-1:0];
    endtask

    task automatic drive_bits(input logic [31:0] word, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = word[nbits-1-i];
            repeat (half) @(negedge clk_50);
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk_50);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input string tag, input logic [31:0] word, input int nbits,
                             input int half, input bit coincide);
        int u0, e0, addr, idle_t;
        bit wr;
        u0     = n_upd;
        e0     = n_err;
        idle_t = $urandom_range(0, 2);
        for (int i = 0; i < idle_t; i++) begin
            spi_mosi = 1'($urandom);
            spi_sclk = 1'b1;
            repeat (half) @(negedge clk_50);
            spi_sclk = 1'b0;
            repeat (half) @(negedge clk_50);
        end
        spi_ss_n = 1'b0;
        repeat (half) @(negedge clk_50);
        drive_bits(word, nbits, half);
        repeat (half) @(negedge clk_50);
        if (coincide) spi_sclk = 1'b1;
        spi_ss_n = 1'b1;
        repeat (LAT + 8) @(negedge clk_50);
        spi_sclk = 1'b0;
        repeat (half) @(negedge clk_50);
        model_frame(word, nbits, wr, addr);
        check_val({tag, " upd"}, n_upd - u0, 32'(wr));
        check_val({tag, " err"}, n_err - e0, 32'(!wr));
        if (wr) check_val({tag, " addr"}, 32'(last_addr), addr);
        check_regs(tag);
    endtask

    initial begin
        logic [31:0] w, fr;
        int          u0, e0, r, addr, data, half, nb;
        bit          bad, wr;

        for (int i = 0; i < 4; i++) exp_reg[i] = RST_VAL;

        reset_n = 1'b0;
        repeat (2) @(negedge clk_50);
        check_regs("reset");
        check_val("reset upd_valid", upd_valid, 0);
        check_val("reset upd_addr", upd_addr, 0);
        check_val("reset frame_err", frame_err, 0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk_50);

        // Valid write to a5 with exact latency from the sampled SS_n rise.
        w  = make_frame(2, 6, 1'b0);
        u0 = n_upd;
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk_50);
        drive_bits(w, FLEN, 4);
        repeat (4) @(negedge clk_50);
        spi_ss_n = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk_50);
            if (k == LAT) begin
                check_val("lat early valid", upd_valid, 0);
                check_val("lat early a5", a5, RST_VAL);
            end
            if (k == LAT + 1) begin
                check_val("lat valid", upd_valid, 1);
                check_val("lat addr", upd_addr, 2);
                check_val("lat a5", a5, 6);
                check_val("lat err", frame_err, 0);
            end
        end
        repeat (8) @(negedge clk_50);
        model_frame(w, FLEN, wr, addr);
        check_val("write upd count", n_upd - u0, 1);
        check_regs("write");

        run_frame("trunc", make_frame(0, 7, 1'b0) >> (FLEN - 10), 10, 4, 1'b0);
        run_frame("overrun", (make_frame(1, 3, 1'b0) << 4) | 32'hA, FLEN + 4, 4, 1'b0);
        run_frame("badaddr", make_frame(5, 3, 1'b0), FLEN, 4, 1'b0);
        run_frame("glitch", 32'h0, 0, 4, 1'b0);
        run_frame("coincide", make_frame(0, 3, 1'b0), FLEN, 4, 1'b1);
`ifdef CTRL_PARITY_EN
        run_frame("par good", make_frame(1, 5, 1'b0), FLEN, 4, 1'b0);
        run_frame("par bad", make_frame(1, 2, 1'b1), FLEN, 4, 1'b0);
        run_frame("par missing", make_frame(1, 1, 1'b0) >> 1, 16, 4, 1'b0);
`endif

        for (int t = 0; t < 30; t++) begin
            r    = $urandom_range(0, 9);
            addr = ($urandom_range(0, 4) < 4) ? $urandom_range(0, 3) : $urandom_range(4, 15);
            data = $urandom_range(0, 4095);
            bad  = ($urandom_range(0, 5) == 0);
            half = $urandom_range(3, 6);
            fr   = make_frame(addr, data, bad);
            nb   = FLEN;
            w    = fr;
            if (r == 7) begin
                nb = $urandom_range(0, FLEN - 1);
                w  = fr >> (FLEN - nb);
            end else if (r == 8) begin
                nb = FLEN + $urandom_range(1, 4);
                w  = (fr << (nb - FLEN)) | 32'($urandom_range(0, 15));
            end
            run_frame($sformatf("rnd%0d", t), w, nb, half, r == 9);
        end

        // Reset after 8 bits; the rest of the frame and its SS_n rise must be ignored.
        u0 = n_upd;
        e0 = n_err;
        w  = make_frame(3, 2, 1'b0);
        spi_ss_n = 1'b0;
        repeat (4) @(negedge clk_50);
        drive_bits(w >> (FLEN - 8), 8, 4);
        reset_n = 1'b0;
        repeat (2) @(negedge clk_50);
        reset_n = 1'b1;
        drive_bits(w, FLEN - 8, 4);
        repeat (4) @(negedge clk_50);
        spi_ss_n = 1'b1;
        repeat (LAT + 8) @(negedge clk_50);
        for (int i = 0; i < 4; i++) exp_reg[i] = RST_VAL;
        check_val("midrst upd", n_upd - u0, 0);
        check_val("midrst err", n_err - e0, 0);
        check_regs("midrst");
        run_frame("after rst", make_frame(3, 1, 1'b0), FLEN, 4, 1'b0);

        check_val("no overlap", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
